// File: rtl/kp_pkg.sv
// rtl/kp_pkg.sv - shared widths, keypoint types and FSM states for keypoint_fetch
package kp_pkg;

    localparam int ADDR_W     = 11;
    localparam int ROW_W      = 9;
    localparam int COL_W      = 10;
    localparam int CNT_W      = 12;
    localparam int FIFO_DEPTH = 2;
    localparam int IMG_ROWS   = 480;
    localparam int IMG_COLS   = 640;
    localparam int BORDER     = 8;

    // Border window limits in field-sized constants so comparisons stay width-matched
    localparam logic [ROW_W-1:0] ROW_MIN = ROW_W'(BORDER);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_ROWS - BORDER - 1);
    localparam logic [COL_W-1:0] COL_MIN = COL_W'(BORDER);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_COLS - BORDER - 1);

    typedef struct packed {
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
    } kp_t;

    typedef struct packed {
        kp_t  kp;
        logic layer;
        logic last;
    } kp_entry_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD1,
        ST_RD2,
        ST_DRAIN,
        ST_FIN
    } state_t;

    // True when the keypoint sits too close to the image edge for a descriptor patch
    function automatic logic kp_in_border(input kp_t k);
        return (k.row < ROW_MIN) || (k.row > ROW_MAX) ||
               (k.col < COL_MIN) || (k.col > COL_MAX);
    endfunction

endpackage

// File: rtl/kp_fifo2.sv
// rtl/kp_fifo2.sv - two-entry output FIFO carrying {row, col, layer, last}
module kp_fifo2
    import kp_pkg::*;
(
    input  logic      i_clk,
    input  logic      i_rst,
    input  logic      i_push,
    input  kp_entry_t i_data,
    input  logic      i_pop,
    output logic      o_valid,
    output kp_entry_t o_data,
    output logic [1:0] o_count
);

    kp_entry_t  r_mem [FIFO_DEPTH];
    logic       r_wptr;
    logic       r_rptr;
    logic [1:0] r_count;
    logic       w_do_push;
    logic       w_do_pop;

    assign w_do_pop  = i_pop && (r_count != 2'd0);
    assign w_do_push = i_push && ((r_count != 2'(FIFO_DEPTH)) || w_do_pop);

    // Storage, pointers and occupancy; reset flushes everything
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wptr] <= i_data;
                r_wptr        <= ~r_wptr;
            end
            if (w_do_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_valid = (r_count != 2'd0);
    assign o_data  = r_mem[r_rptr];
    assign o_count = r_count;

endmodule

// File: rtl/keypoint_fetch.sv
// rtl/keypoint_fetch.sv - walks both keypoint SRAMs and streams entries out; KP_BORDER_DROP_EN drops border keypoints
module keypoint_fetch
    import kp_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [CNT_W-1:0]       kp1_count,
    input  logic [CNT_W-1:0]       kp2_count,
    output logic [ADDR_W-1:0]      keypoint_1_addr,
    input  logic [ROW_W+COL_W-1:0] keypoint_1_dout,
    output logic [ADDR_W-1:0]      keypoint_2_addr,
    input  logic [ROW_W+COL_W-1:0] keypoint_2_dout,
    output logic                   kp_valid,
    input  logic                   kp_ready,
    output logic [ROW_W-1:0]       kp_row,
    output logic [COL_W-1:0]       kp_col,
    output logic                   kp_layer,
    output logic                   kp_last,
    output logic                   busy,
    output logic                   done
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt1;
    logic [CNT_W-1:0] r_cnt2;
    logic [CNT_W-1:0] r_rd_cnt;
    logic [ADDR_W-1:0] r_addr1;
    logic [ADDR_W-1:0] r_addr2;
    logic             r_inflight;
    logic             r_tag_layer;
    logic             r_tag_last;
    logic             r_done;

    logic             w_reading;
    logic             w_pop;
    logic [2:0]       w_used;
    logic             w_credit;
    logic             w_issue;
    logic             w_layer_end;
    logic             w_final;
    logic             w_push;
    kp_entry_t        w_push_data;
    kp_entry_t        w_head;
    logic             w_fifo_valid;
    logic [1:0]       w_fifo_count;
    logic             w_hold_cnt;
    logic             w_flight_idle;
    kp_t              w_rd_kp;

    assign w_reading   = (r_state == ST_RD1) || (r_state == ST_RD2);
    assign w_pop       = w_fifo_valid && kp_ready;
    // Everything already committed to an output slot, minus the slot freed this cycle
    assign w_used      = 3'(w_fifo_count) + 3'(r_inflight) + 3'(w_hold_cnt) - 3'(w_pop);
    assign w_credit    = (w_used < 3'd2);
    assign w_issue     = !rst && w_reading && w_credit;
    assign w_layer_end = (r_state == ST_RD1) ? (r_rd_cnt == r_cnt1 - CNT_ONE)
                                             : (r_rd_cnt == r_cnt2 - CNT_ONE);
    assign w_final     = w_layer_end && ((r_state == ST_RD2) || (r_cnt2 == '0));

    // Address is driven combinationally on issue so data returns on the next cycle
    assign keypoint_1_addr = (w_issue && (r_state == ST_RD1)) ? r_rd_cnt[ADDR_W-1:0] : r_addr1;
    assign keypoint_2_addr = (w_issue && (r_state == ST_RD2)) ? r_rd_cnt[ADDR_W-1:0] : r_addr2;

    assign w_rd_kp = r_tag_layer ? kp_t'(keypoint_2_dout) : kp_t'(keypoint_1_dout);

`ifdef KP_BORDER_DROP_EN
    logic r_hold_v;
    logic r_hold_fin;
    kp_t  r_hold_kp;
    logic r_hold_layer;
    logic w_keep;

    assign w_keep     = r_inflight && !kp_in_border(w_rd_kp);
    assign w_hold_cnt = r_hold_v;

    // Held survivor is released when a newer survivor arrives or the run's final read lands
    always_comb begin
        w_push      = 1'b0;
        w_push_data = '0;
        if (r_hold_v && r_hold_fin) begin
            w_push      = 1'b1;
            w_push_data = {r_hold_kp, r_hold_layer, 1'b1};
        end else if (r_hold_v && w_keep) begin
            w_push      = 1'b1;
            w_push_data = {r_hold_kp, r_hold_layer, 1'b0};
        end else if (r_hold_v && r_inflight && r_tag_last) begin
            w_push      = 1'b1;
            w_push_data = {r_hold_kp, r_hold_layer, 1'b1};
        end
    end

    // Lookahead hold register so the last survivor is known before it enters the FIFO
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_v     <= 1'b0;
            r_hold_fin   <= 1'b0;
            r_hold_kp    <= '0;
            r_hold_layer <= 1'b0;
        end else if (r_hold_v && r_hold_fin) begin
            r_hold_v   <= 1'b0;
            r_hold_fin <= 1'b0;
        end else if (w_keep) begin
            r_hold_v     <= 1'b1;
            r_hold_fin   <= r_tag_last;
            r_hold_kp    <= w_rd_kp;
            r_hold_layer <= r_tag_layer;
        end else if (r_inflight && r_tag_last) begin
            r_hold_v <= 1'b0;
        end
    end
`else
    assign w_hold_cnt  = 1'b0;
    assign w_push      = r_inflight;
    assign w_push_data = {w_rd_kp, r_tag_layer, r_tag_last};
`endif

    assign w_flight_idle = !w_fifo_valid && !r_inflight && !w_hold_cnt;

    kp_fifo2 u_fifo (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_valid (w_fifo_valid),
        .o_data  (w_head),
        .o_count (w_fifo_count)
    );

    // Next-state selection for the walk through layer 0, layer 1, drain and finish
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (kp1_count != '0)      w_next = ST_RD1;
                    else if (kp2_count != '0) w_next = ST_RD2;
                    else                      w_next = ST_FIN;
                end
            end
            ST_RD1: begin
                if (w_issue && w_layer_end) w_next = (r_cnt2 != '0) ? ST_RD2 : ST_DRAIN;
            end
            ST_RD2: begin
                if (w_issue && w_layer_end) w_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (w_flight_idle) w_next = ST_FIN;
            end
            ST_FIN:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // State, latched counts, read counter, held addresses and the read-tag pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt1      <= '0;
            r_cnt2      <= '0;
            r_rd_cnt    <= '0;
            r_addr1     <= '0;
            r_addr2     <= '0;
            r_inflight  <= 1'b0;
            r_tag_layer <= 1'b0;
            r_tag_last  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_addr1     <= keypoint_1_addr;
            r_addr2     <= keypoint_2_addr;
            r_inflight  <= w_issue;
            r_tag_layer <= (r_state == ST_RD2);
            r_tag_last  <= w_issue && w_final;
            r_done      <= (r_state == ST_FIN);
            if ((r_state == ST_IDLE) && start) begin
                r_cnt1   <= kp1_count;
                r_cnt2   <= kp2_count;
                r_rd_cnt <= '0;
            end else if (w_issue) begin
                r_rd_cnt <= w_layer_end ? '0 : r_rd_cnt + CNT_ONE;
            end
        end
    end

    assign kp_valid = w_fifo_valid;
    assign kp_row   = w_head.kp.row;
    assign kp_col   = w_head.kp.col;
    assign kp_layer = w_head.layer;
    assign kp_last  = w_head.last;
    assign busy     = w_reading || (r_state == ST_DRAIN);
    assign done     = r_done;

endmodule

// File: tb/tb_keypoint_fetch.sv
// tb/tb_keypoint_fetch.sv - scoreboard bench for keypoint_fetch with a list-level reference model
module tb_keypoint_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [11:0] kp1_count = '0;
    logic [11:0] kp2_count = '0;
    logic [10:0] a1, a2;
    logic [18:0] d1 = '0, d2 = '0;
    logic        kp_valid, kp_ready = 1'b1;
    logic [8:0]  kp_row;
    logic [9:0]  kp_col;
    logic        kp_layer, kp_last, busy, done;

    keypoint_fetch dut (
        .clk(clk), .rst(rst), .start(start),
        .kp1_count(kp1_count), .kp2_count(kp2_count),
        .keypoint_1_addr(a1), .keypoint_1_dout(d1),
        .keypoint_2_addr(a2), .keypoint_2_dout(d2),
        .kp_valid(kp_valid), .kp_ready(kp_ready),
        .kp_row(kp_row), .kp_col(kp_col), .kp_layer(kp_layer), .kp_last(kp_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [18:0] mem1 [0:2047];
    logic [18:0] mem2 [0:2047];

    always @(posedge clk) begin
        d1 <= mem1[a1];
        d2 <= mem2[a2];
    end

    typedef struct packed {
        logic [8:0] row;
        logic [9:0] col;
        logic       layer;
        logic       last;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   chk = 0, err = 0;
    int   xfers, dones, first_x, last_x, cyc = 0;
    int   rdy_mode = 0;
    logic prev_stall = 1'b0;
    logic [20:0] prev_pl;

    task automatic check(input string name, input int act, input int exp);
        chk++;
        if (act != exp) begin
            err++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic bit drop(input logic [18:0] w);
`ifdef KP_BORDER_DROP_EN
        int r = int'(w[18:10]);
        int c = int'(w[9:0]);
        return (r < 8) || (r > 471) || (c < 8) || (c > 631);
`else
        return (w == 19'h7ffff) && (w != 19'h7ffff);
`endif
    endfunction

    // Reference: list of surviving entries in read order, last flag on the final one
    function automatic int build(input int n1, input int n2);
        exp_t t[$];
        exp_t x;
        for (int i = 0; i < n1; i++)
            if (!drop(mem1[i])) begin x = {mem1[i], 1'b0, 1'b0}; t.push_back(x); end
        for (int i = 0; i < n2; i++)
            if (!drop(mem2[i])) begin x = {mem2[i], 1'b1, 1'b0}; t.push_back(x); end
        if (t.size() > 0) t[t.size()-1].last = 1'b1;
        foreach (t[i]) sb.push_back(t[i]);
        return t.size();
    endfunction

    always @(posedge clk) cyc++;

    // Ready pattern driven just after each rising edge
    initial forever begin
        @(posedge clk);
        #2;
        case (rdy_mode)
            0: kp_ready = 1'b1;
            1: kp_ready = ~kp_ready;
            2: kp_ready = 1'($urandom_range(0, 1));
            default: kp_ready = 1'b0;
        endcase
    end

    // Monitor: pops the scoreboard on every transfer, checks stall stability
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", int'(kp_valid), 1);
                check("stall_payload", int'({kp_row, kp_col, kp_layer, kp_last}), int'(prev_pl));
            end
            if (kp_valid && kp_ready) begin
                xfers++;
                if (first_x < 0) first_x = cyc;
                last_x = cyc;
                if (sb.size() == 0) begin
                    chk++; err++;
                    $display("FAIL unexpected_xfer actual=(%0d,%0d) required=none", kp_row, kp_col);
                end else begin
                    e = sb.pop_front();
                    check("row", int'(kp_row), int'(e.row));
                    check("col", int'(kp_col), int'(e.col));
                    check("layer", int'(kp_layer), int'(e.layer));
                    check("last", int'(kp_last), int'(e.last));
                end
            end
            if (done) dones++;
            prev_stall = kp_valid && !kp_ready;
            prev_pl = {kp_row, kp_col, kp_layer, kp_last};
        end
    end

    task automatic run_case(input int n1, input int n2, input int mode, output int lat);
        int nexp;
        kp1_count = 12'(n1);
        kp2_count = 12'(n2);
        rdy_mode = mode;
        nexp = build(n1, n2);
        xfers = 0; dones = 0; first_x = -1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        if (n1 + n2 > 0) check("busy_after_start", int'(busy), 1);
        while (!done && lat < 20000) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!done) begin
            chk++; err++;
            $display("FAIL done_timeout actual=%0d cycles required=done", lat);
        end
        check("busy_at_done", int'(busy), 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("xfer_count", xfers, nexp);
        check("sb_empty", sb.size(), 0);
        check("done_pulses", dones, 1);
        sb.delete();
    endtask

    int   lat;
    logic [10:0] a1_before, a2_before;

    initial begin
        for (int i = 0; i < 2048; i++) begin
            mem1[i] = 19'($urandom);
            mem2[i] = 19'($urandom);
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_valid", int'(kp_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_addr1", int'(a1), 0);
        check("rst_addr2", int'(a2), 0);

        // Two layers back to back, full throughput
        mem1[0] = {9'd5, 10'd10}; mem1[1] = {9'd6, 10'd20}; mem1[2] = {9'd7, 10'd30};
        mem2[0] = {9'd100, 10'd200}; mem2[1] = {9'd101, 10'd201};
        run_case(3, 2, 0, lat);
        check("consecutive_span", last_x - first_x, 4);

        // Both counts zero
        a1_before = a1; a2_before = a2;
        run_case(0, 0, 0, lat);
        check("zero_done_latency", lat, 2);
        check("zero_addr1_hold", int'(a1), int'(a1_before));
        check("zero_addr2_hold", int'(a2), int'(a2_before));

        // Alternating backpressure
        run_case(4, 0, 1, lat);

        // Only layer 1, single entry
        a1_before = a1;
        run_case(0, 1, 0, lat);
        check("l2only_addr1_hold", int'(a1), int'(a1_before));
        check("l2only_addr2", int'(a2), 0);

        // Reset mid-run with entries buffered, then replay
        kp1_count = 12'd10; kp2_count = 12'd0; rdy_mode = 3;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("pre_rst_valid", int'(kp_valid), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("post_rst_valid", int'(kp_valid), 0);
        check("post_rst_busy", int'(busy), 0);
        sb.delete();
        run_case(10, 0, 0, lat);

        // Randomised runs under random backpressure
        for (int k = 0; k < 6; k++)
            run_case(int'($urandom_range(0, 20)), int'($urandom_range(0, 20)), 2, lat);

        // Full 2048-entry layer
        run_case(2048, 3, 2, lat);

`ifdef KP_BORDER_DROP_EN
        mem1[0] = {9'd3, 10'd50}; mem1[1] = {9'd50, 10'd50}; mem1[2] = {9'd50, 10'd635};
        run_case(3, 0, 0, lat);
        check("border_single", xfers, 1);
        mem1[0] = {9'd3, 10'd50}; mem1[1] = {9'd500, 10'd50};
        run_case(2, 0, 0, lat);
`endif

        $display("CHECKS %0d ERRORS %0d", chk, err);
        $finish;
    end

endmodule
